// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter sharing one 8-bit ALU between two valid/ready requesters.
// Optional flags (rsp_zero/rsp_carry) are enabled by defining ALU_SHARE_FLAGS_EN.
module alu_share_arbiter #(
    parameter bit RR_INIT = 1'b0,
    localparam int unsigned DW = 8,
    localparam int unsigned OW = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req0_valid,
    output logic          req0_ready,
    input  logic [OW-1:0] req0_op,
    input  logic [DW-1:0] req0_a,
    input  logic [DW-1:0] req0_b,
    input  logic          req1_valid,
    output logic          req1_ready,
    input  logic [OW-1:0] req1_op,
    input  logic [DW-1:0] req1_a,
    input  logic [DW-1:0] req1_b,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic          rsp_id,
    output logic [DW-1:0] rsp_data,
`ifdef ALU_SHARE_FLAGS_EN
    output logic          rsp_zero,
    output logic          rsp_carry,
`endif
    output logic          busy
);

    localparam logic [OW-1:0] OP_ADD = 2'b00;
    localparam logic [OW-1:0] OP_SUB = 2'b01;
    localparam logic [OW-1:0] OP_AND = 2'b10;

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    typedef struct packed {
        logic [OW-1:0] op;
        logic [DW-1:0] a;
        logic [DW-1:0] b;
    } alu_req_t;

    state_t        state, state_nx;
    alu_req_t      req_q, req_nx, sel_req;
    logic          prio_q, prio_nx;
    logic          grant1, any_valid;
    logic          rsp_valid_nx, rsp_id_nx, busy_nx;
    logic [DW-1:0] rsp_data_nx, alu_res;
`ifdef ALU_SHARE_FLAGS_EN
    logic          alu_carry, rsp_zero_nx, rsp_carry_nx;
`endif

    // Arbitration: a lone valid wins; on a tie the priority pointer decides.
    assign any_valid = req0_valid | req1_valid;
    assign grant1    = req1_valid & (~req0_valid | prio_q);
    assign sel_req   = grant1 ? alu_req_t'{req1_op, req1_a, req1_b}
                              : alu_req_t'{req0_op, req0_a, req0_b};

    // Shared ALU, fed only from the captured operand registers.
    always_comb begin
        alu_res = '0;
`ifdef ALU_SHARE_FLAGS_EN
        alu_carry = 1'b0;
`endif
        case (req_q.op)
            OP_ADD: begin
`ifdef ALU_SHARE_FLAGS_EN
                {alu_carry, alu_res} = {1'b0, req_q.a} + {1'b0, req_q.b};
`else
                alu_res = req_q.a + req_q.b;
`endif
            end
            OP_SUB: begin
                alu_res = req_q.a - req_q.b;
`ifdef ALU_SHARE_FLAGS_EN
                alu_carry = (req_q.a < req_q.b);
`endif
            end
            OP_AND:  alu_res = req_q.a & req_q.b;
            default: alu_res = req_q.a | req_q.b;
        endcase
    end

    // Next-state and ready logic.
    always_comb begin
        state_nx     = state;
        req_nx       = req_q;
        prio_nx      = prio_q;
        rsp_valid_nx = rsp_valid;
        rsp_id_nx    = rsp_id;
        rsp_data_nx  = rsp_data;
        busy_nx      = busy;
        req0_ready   = 1'b0;
        req1_ready   = 1'b0;
`ifdef ALU_SHARE_FLAGS_EN
        rsp_zero_nx  = rsp_zero;
        rsp_carry_nx = rsp_carry;
`endif
        case (state)
            IDLE: begin
                req0_ready = req0_valid & ~grant1;
                req1_ready = grant1;
                if (any_valid) begin
                    req_nx    = sel_req;
                    rsp_id_nx = grant1;
                    busy_nx   = 1'b1;
                    state_nx  = EXEC;
                end
            end
            EXEC: begin
                rsp_data_nx  = alu_res;
                rsp_valid_nx = 1'b1;
`ifdef ALU_SHARE_FLAGS_EN
                rsp_zero_nx  = (alu_res == '0);
                rsp_carry_nx = alu_carry;
`endif
                state_nx     = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_nx = 1'b0;
                    busy_nx      = 1'b0;
                    prio_nx      = ~rsp_id;
                    state_nx     = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            req_q     <= '0;
            prio_q    <= RR_INIT;
            rsp_valid <= 1'b0;
            rsp_id    <= 1'b0;
            rsp_data  <= '0;
            busy      <= 1'b0;
`ifdef ALU_SHARE_FLAGS_EN
            rsp_zero  <= 1'b0;
            rsp_carry <= 1'b0;
`endif
        end else begin
            state     <= state_nx;
            req_q     <= req_nx;
            prio_q    <= prio_nx;
            rsp_valid <= rsp_valid_nx;
            rsp_id    <= rsp_id_nx;
            rsp_data  <= rsp_data_nx;
            busy      <= busy_nx;
`ifdef ALU_SHARE_FLAGS_EN
            rsp_zero  <= rsp_zero_nx;
            rsp_carry <= rsp_carry_nx;
`endif
        end
    end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Self-checking bench for alu_share_arbiter: directed scenarios plus random
// traffic compared every cycle against a transaction-level reference model.
module tb_alu_share_arbiter;

    localparam bit RR_INIT = 1'b0;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       req0_valid = 1'b0, req1_valid = 1'b0;
    logic       req0_ready, req1_ready;
    logic [1:0] req0_op = '0, req1_op = '0;
    logic [7:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
    logic       rsp_valid, rsp_ready = 1'b1, rsp_id, busy;
    logic [7:0] rsp_data;
`ifdef ALU_SHARE_FLAGS_EN
    logic       rsp_zero, rsp_carry;
`endif

    always #5 clk = ~clk;

    alu_share_arbiter #(.RR_INIT(RR_INIT)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
        .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
        .req1_a(req1_a), .req1_b(req1_b),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_data(rsp_data),
`ifdef ALU_SHARE_FLAGS_EN
        .rsp_zero(rsp_zero), .rsp_carry(rsp_carry),
`endif
        .busy(busy)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference ALU: returns {carry/borrow, result} from plain integer arithmetic.
    function automatic logic [8:0] ref_alu(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
        int s;
        case (op)
            2'd0: begin s = int'(a) + int'(b); return {s > 255, 8'(s % 256)}; end
            2'd1: begin s = int'(a) - int'(b); return {s < 0, 8'((s + 256) % 256)}; end
            2'd2: return {1'b0, a & b};
            default: return {1'b0, a | b};
        endcase
    endfunction

    // Transaction model: one in-flight op, visible two cycles after acceptance.
    bit         m_ok = 0, m_busy = 0, m_id = 0, m_ptr = RR_INIT, m_carry = 0, mw1;
    int         m_age = 0;
    logic [7:0] m_data = '0;

    always @(negedge clk) begin
        mw1 = req1_valid && (!req0_valid || m_ptr);
        if (m_ok) begin
            chk("req0_ready", req0_ready, !m_busy && req0_valid && !mw1);
            chk("req1_ready", req1_ready, !m_busy && mw1);
            chk("busy", busy, m_busy);
            chk("rsp_valid", rsp_valid, m_busy && m_age >= 2);
            if (m_busy && m_age >= 2) begin
                chk("rsp_id", rsp_id, m_id);
                chk("rsp_data", rsp_data, m_data);
`ifdef ALU_SHARE_FLAGS_EN
                chk("rsp_zero", rsp_zero, m_data == 8'h00);
                chk("rsp_carry", rsp_carry, m_carry);
`endif
            end
        end
        if (reset) begin
            m_ok = 1; m_busy = 0; m_ptr = RR_INIT; m_age = 0;
        end else if (m_ok) begin
            if (!m_busy) begin
                if (req0_valid || req1_valid) begin
                    m_busy = 1; m_age = 1; m_id = mw1;
                    {m_carry, m_data} = mw1 ? ref_alu(req1_op, req1_a, req1_b)
                                            : ref_alu(req0_op, req0_a, req0_b);
                end
            end else if (m_age >= 2 && rsp_ready) begin
                m_busy = 0; m_ptr = ~m_id;
            end else begin
                m_age++;
            end
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        reset = 1; req0_valid = 0; req1_valid = 0; rsp_ready = 1;
        tick(); tick();
        reset = 0;
    endtask

    // Wait (bounded) for rsp_valid; returns positioned at that cycle's negedge.
    task automatic wait_rsp(input string name);
        int n = 0;
        @(negedge clk);
        while (!rsp_valid && n < 20) begin tick(); @(negedge clk); n++; end
        chk({name, " rsp_valid"}, rsp_valid, 1);
    endtask

    // Issue one op from a single requester and wait for its response.
    task automatic single_op(input bit id, input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
        tick();
        if (id) begin req1_valid = 1; req1_op = op; req1_a = a; req1_b = b; end
        else    begin req0_valid = 1; req0_op = op; req0_a = a; req0_b = b; end
        @(negedge clk);
        chk("single grant", id ? req1_ready : req0_ready, 1);
        tick();
        req0_valid = 0; req1_valid = 0;
        wait_rsp("single");
    endtask

    int         g_id[$], g_cyc[$], r_cyc[$];
    bit         r_id[$];
    logic [7:0] r_dat[$];

    task automatic run_log(input int n, input bit hold);
        bit t0, t1;
        g_id.delete(); g_cyc.delete(); r_cyc.delete(); r_id.delete(); r_dat.delete();
        for (int c = 1; c <= n; c++) begin
            @(negedge clk);
            t0 = req0_valid && req0_ready;
            t1 = req1_valid && req1_ready;
            if (t0) begin g_id.push_back(0); g_cyc.push_back(c); end
            if (t1) begin g_id.push_back(1); g_cyc.push_back(c); end
            if (rsp_valid && rsp_ready) begin
                r_id.push_back(rsp_id); r_dat.push_back(rsp_data); r_cyc.push_back(c);
            end
            tick();
            if (!hold && t0) req0_valid = 0;
            if (!hold && t1) req1_valid = 0;
        end
    endtask

    function automatic logic [7:0] rnd8();
        case ($urandom_range(0, 3))
            0: return 8'h00;
            1: return 8'hFF;
            default: return 8'($urandom);
        endcase
    endfunction

    initial begin
        bit t0, t1;

        // Reset values and single add latency.
        do_reset();
        @(negedge clk);
        chk("rst rsp_valid", rsp_valid, 0);
        chk("rst busy", busy, 0);
        chk("rst rsp_data", rsp_data, 8'h00);
        chk("rst rsp_id", rsp_id, 0);
        tick();
        req0_valid = 1; req0_op = 2'd0; req0_a = 8'h12; req0_b = 8'h34;
        @(negedge clk);
        chk("t1 req0_ready N", req0_ready, 1);
        tick(); req0_valid = 0;
        @(negedge clk);
        chk("t1 busy N+1", busy, 1);
        chk("t1 rsp_valid N+1", rsp_valid, 0);
        tick();
        @(negedge clk);
        chk("t1 rsp_valid N+2", rsp_valid, 1);
        chk("t1 rsp_data", rsp_data, 8'h46);
        chk("t1 rsp_id", rsp_id, 0);
        tick();
        @(negedge clk);
        chk("t1 busy N+3", busy, 0);
        tick();

        // Both valid: req0 sub then req1 OR.
        do_reset();
        req0_valid = 1; req0_op = 2'd1; req0_a = 8'h03; req0_b = 8'h05;
        req1_valid = 1; req1_op = 2'd3; req1_a = 8'hF0; req1_b = 8'h0F;
        run_log(10, 0);
        chk("t2 grants", g_id.size(), 2);
        chk("t2 rsps", r_id.size(), 2);
        if (g_id.size() == 2 && r_id.size() == 2) begin
            chk("t2 first grant id", g_id[0], 0);
            chk("t2 rsp0 id", r_id[0], 0);
            chk("t2 rsp0 data", r_dat[0], 8'hFE);
            chk("t2 rsp1 id", r_id[1], 1);
            chk("t2 rsp1 data", r_dat[1], 8'hFF);
            chk("t2 req1 after rsp0", g_cyc[1] > r_cyc[0], 1);
        end

        // Both held: strict alternation, one response per 3 cycles.
        do_reset();
        req0_valid = 1; req0_op = 2'd0; req0_a = 8'h01; req0_b = 8'h02;
        req1_valid = 1; req1_op = 2'd1; req1_a = 8'h10; req1_b = 8'h01;
        run_log(13, 1);
        chk("t3 rsps", r_id.size() >= 4, 1);
        if (r_id.size() >= 4) begin
            for (int i = 0; i < 4; i++) begin
                chk("t3 id seq", r_id[i], i % 2);
                chk("t3 data seq", r_dat[i], (i % 2) ? 8'h0F : 8'h03);
                if (i > 0) chk("t3 spacing", r_cyc[i] - r_cyc[i-1], 3);
            end
        end

        // Backpressure in RESP.
        do_reset();
        rsp_ready = 0;
        req1_valid = 1; req1_op = 2'd2; req1_a = 8'hF0; req1_b = 8'h3C;
        tick();
        req1_valid = 0;
        req0_valid = 1; req0_op = 2'd0; req0_a = 8'h01; req0_b = 8'h01;
        wait_rsp("t4");
        for (int k = 0; k < 5; k++) begin
            if (k > 0) @(negedge clk);
            chk("t4 hold valid", rsp_valid, 1);
            chk("t4 hold data", rsp_data, 8'h30);
            chk("t4 hold id", rsp_id, 1);
            chk("t4 req0_ready", req0_ready, 0);
            tick();
        end
        rsp_ready = 1;
        @(negedge clk);
        chk("t4 final valid", rsp_valid, 1);
        tick();
        @(negedge clk);
        chk("t4 done valid", rsp_valid, 0);
        chk("t4 req0 next", req0_ready, 1);
        tick();
        req0_valid = 0;

        // Wrap-around and flags.
        do_reset();
        single_op(0, 2'd0, 8'hFF, 8'h01);
        chk("t5 add wrap", rsp_data, 8'h00);
`ifdef ALU_SHARE_FLAGS_EN
        chk("t5 add zero", rsp_zero, 1);
        chk("t5 add carry", rsp_carry, 1);
`endif
        single_op(1, 2'd2, 8'hAA, 8'h55);
        chk("t5 and", rsp_data, 8'h00);
`ifdef ALU_SHARE_FLAGS_EN
        chk("t5 and carry", rsp_carry, 0);
`endif
        single_op(0, 2'd1, 8'h03, 8'h05);
        chk("t5 sub", rsp_data, 8'hFE);

        // Reset while in RESP discards the transaction and the pointer.
        do_reset();
        single_op(0, 2'd0, 8'h01, 8'h01);
        chk("t6 first", rsp_data, 8'h02);
        tick();
        rsp_ready = 0;
        req1_valid = 1; req1_op = 2'd3; req1_a = 8'h0C; req1_b = 8'h30;
        @(negedge clk);
        chk("t6 req1 grant", req1_ready, 1);
        tick(); req1_valid = 0;
        wait_rsp("t6");
        tick();
        reset = 1;
        tick();
        reset = 0; rsp_ready = 1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("t6 no stale valid", rsp_valid, 0);
            chk("t6 busy", busy, 0);
            tick();
        end
        req0_valid = 1; req1_valid = 1;
        @(negedge clk);
        chk("t6 ptr reset r0", req0_ready, 1);
        chk("t6 ptr reset r1", req1_ready, 0);
        tick();
        req0_valid = 0; req1_valid = 0;
        repeat (4) tick();

        // Random traffic against the model.
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            t0 = req0_valid && req0_ready && !reset;
            t1 = req1_valid && req1_ready && !reset;
            tick();
            reset = ($urandom_range(0, 299) == 0);
            rsp_ready = ($urandom_range(0, 3) != 0);
            if (t0 || !req0_valid) begin
                req0_valid = 1'($urandom_range(0, 1));
                req0_op = 2'($urandom); req0_a = rnd8(); req0_b = rnd8();
            end else if ($urandom_range(0, 19) == 0) begin
                req0_valid = 0;
            end
            if (t1 || !req1_valid) begin
                req1_valid = 1'($urandom_range(0, 1));
                req1_op = 2'($urandom); req1_a = rnd8(); req1_b = rnd8();
            end else if ($urandom_range(0, 19) == 0) begin
                req1_valid = 0;
            end
        end
        reset = 0; req0_valid = 0; req1_valid = 0; rsp_ready = 1;
        repeat (6) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
